// File: rtl/instr_sequencer_if.sv
// Host/core-facing signal bundle of the instruction sequencer: program loader,
// run control, core flag feedback and the issued instruction stream.
interface instr_sequencer_if #(
    parameter int AW = 4
);
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [11:0]   prog_wdata;
    logic          start;
    logic          stop;
    logic [2:0]    flag_cmp;
    logic [7:0]    instruction;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;

    modport master (
        output prog_we, prog_addr, prog_wdata, start, stop, flag_cmp,
        input  instruction, pc, busy, halted
    );

    modport slave (
        input  prog_we, prog_addr, prog_wdata, start, stop, flag_cmp,
        output instruction, pc, busy, halted
    );
endinterface

// File: rtl/instr_sequencer.sv
// Program store plus control-flow sequencer feeding the 8-bit micro core.
// Optional CMP_INTERLOCK_EN: one-cycle stall of a JC that directly follows a CM/CMI.
module instr_sequencer #(
    parameter int         AW        = 4,
    parameter logic [7:0] NOP_INSTR = 8'h30
) (
    input  logic                clk,
    input  logic                rst,
    instr_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_e;

    localparam int DEPTH = 2 ** AW;

    logic [11:0]   mem_q [DEPTH];
    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    instr_q, instr_d;
    logic [7:0]    cnt_q, cnt_d;

    logic [11:0]   word;
    logic [3:0]    ctrl;
    logic [7:0]    payload;
    logic [AW-1:0] target;
    logic [AW-1:0] pc_inc;
    logic          jc_hit;
    logic          stall;

    assign word    = mem_q[pc_q];
    assign ctrl    = word[11:8];
    assign payload = word[7:0];
    assign target  = payload[AW-1:0];
    assign pc_inc  = pc_q + AW'(1);
    assign jc_hit  = |(bus.flag_cmp & payload[6:4]);

`ifdef CMP_INTERLOCK_EN
    // CM (0x7_) and CMI (0xF_) only update flag_cmp two cycles after issue.
    assign stall = (ctrl == 4'b0010) && (instr_q[6:4] == 3'b111);
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    instr_d = NOP_INSTR;
                end
            end
            S_RUN: begin
                instr_d = NOP_INSTR;
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (!stall) begin
                    case (ctrl)
                        4'b0000: begin
                            instr_d = payload;
                            pc_d    = pc_inc;
                        end
                        4'b0001: pc_d = target;
                        4'b0010: pc_d = jc_hit ? target : pc_inc;
                        4'b0011: state_d = S_HALTED;
                        4'b0101: begin
                            cnt_d = payload;
                            pc_d  = pc_inc;
                        end
                        4'b0110: begin
                            if (cnt_q != 8'd0) begin
                                cnt_d = cnt_q - 8'd1;
                                pc_d  = target;
                            end else begin
                                pc_d  = pc_inc;
                            end
                        end
                        default: pc_d = pc_inc;
                    endcase
                end
            end
            S_HALTED: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    instr_d = NOP_INSTR;
                end else if (bus.start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    instr_d = NOP_INSTR;
                end
            end
            default: begin
                state_d = S_IDLE;
                instr_d = NOP_INSTR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Program store is not reset; it is only writable while idle.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && bus.prog_we) begin
            mem_q[bus.prog_addr] <= bus.prog_wdata;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = (state_q == S_RUN);
    assign bus.halted      = (state_q == S_HALTED);

endmodule
